// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller sharing one BCD-to-7-segment decoder across NUM_DIGITS common-anode digits
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   load       one-cycle strobe, captures digits_in into the pending buffer
//   digits_in  packed BCD, digit i at [4i+3:4i]
//   bcd_out    BCD code of the current slot, to the shared decoder
//   an         active-low anode enables, at most one low
//   pending    pending buffer holds uncommitted data
//   frame_done one-cycle pulse at each frame boundary (commit point)
//   Define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zeros.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_done
);
    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] SCAN  = 1'b1;

    logic [0:0]              state, nxt_state;
    logic [CW-1:0]           cnt, nxt_cnt;
    logic [IW-1:0]           idx, nxt_idx;
    logic [4*NUM_DIGITS-1:0] active, nxt_active, pend_buf;
    logic [3:0]              nxt_dig;
    logic [NUM_DIGITS-1:0]   nxt_an;
    logic [NUM_DIGITS:0]     lz;
    logic                    cnt_end, wrap;

    // Outputs are registered from the next-state values so they line up
    // with the state of the cycle they are presented in.
    always_comb begin
        cnt_end    = (state == SCAN) ? (cnt == CW'(REFRESH_DIV - 1)) : (cnt == CW'(BLANK_CYCLES - 1));
        wrap       = (state == SCAN) && cnt_end && (idx == IW'(NUM_DIGITS - 1));
        nxt_state  = cnt_end ? ~state : state;
        nxt_cnt    = cnt_end ? '0 : cnt + CW'(1);
        nxt_idx    = ((state == SCAN) && cnt_end) ? (wrap ? '0 : idx + IW'(1)) : idx;
        nxt_active = (wrap && pending) ? pend_buf : active;
        nxt_dig    = nxt_active[4*nxt_idx +: 4];
        lz         = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // lz[i]: digit i and everything above it are zero; digit 0 is never blanked
        lz[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--)
            lz[i] = (nxt_active[4*i +: 4] == 4'd0) && lz[i+1];
`endif
        nxt_an = ((nxt_state == SCAN) && !((nxt_dig > 4'd9) || lz[nxt_idx])) ?
                 ~(NUM_DIGITS'(1) << nxt_idx) : '1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            pend_buf   <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= '1;
            bcd_out    <= '0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            idx        <= nxt_idx;
            active     <= nxt_active;
            // a load on the boundary edge commits the old buffer and refills it
            pend_buf   <= load ? digits_in : pend_buf;
            pending    <= load | (pending & ~wrap);
            frame_done <= wrap;
            an         <= nxt_an;
            bcd_out    <= nxt_dig;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: self-checking bench for seg7_scan_ctrl (4 digits, 4-cycle slots, 2-cycle blanking)
module tb_seg7_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 2;
    localparam int SLOT = RD + BC;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    int total = 0;
    int bad = 0;

    int          t = 0;
    logic [15:0] mact = '0;
    logic [15:0] mbuf = '0;
    logic        mpend = 1'b0;
    logic [3:0]  prev_bcd = '0;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .digits_in(digits_in),
        .bcd_out(bcd_out), .an(an), .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", nm, got, exp, t);
        end
    endtask

    function automatic logic [3:0] dig(input logic [15:0] v, input int k);
        return v[4*k +: 4];
    endfunction

    function automatic bit dark(input logic [15:0] v, input int k);
        bit allz;
        if (dig(v, k) > 4'd9) return 1'b1;
        allz = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (k > 0) begin
            allz = 1'b1;
            for (int j = k; j < ND; j++) if (dig(v, j) != 4'd0) allz = 1'b0;
        end
`endif
        return allz;
    endfunction

    // Reference model: cycle number since reset release, displayed value, pending buffer
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t     <= 0;
            mact  <= '0;
            mbuf  <= '0;
            mpend <= 1'b0;
        end else begin
            t <= t + 1;
            if ((t + 1) % FRAME == 0 && mpend) mact <= mbuf;
            if (load) begin
                mbuf  <= digits_in;
                mpend <= 1'b1;
            end else if ((t + 1) % FRAME == 0) mpend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        int pos, slot;
        logic [3:0] ea;
        pos  = t % FRAME;
        slot = pos / SLOT;
        ea   = ((pos % SLOT) >= BC && !dark(mact, slot)) ? ~(4'b0001 << slot) : 4'hF;
        chk("an", 32'(an), 32'(ea));
        chk("bcd_out", 32'(bcd_out), 32'(dig(mact, slot)));
        chk("pending", 32'(pending), 32'(mpend));
        chk("frame_done", 32'(frame_done), (t > 0 && pos == 0) ? 1 : 0);
        chk("one_anode", ($countones(~an) <= 1) ? 1 : 0, 1);
        if (reset_n && bcd_out != prev_bcd) chk("bcd_stable", 32'(an), 'hF);
        prev_bcd = bcd_out;
    end

    task automatic wait_cyc(input int c);
        int k;
        k = 0;
        while (t < c && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (t != c) chk("wait_cyc", t, c);
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        digits_in = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    function automatic logic [15:0] rnd_digits();
        logic [15:0] v;
        int r;
        for (int i = 0; i < ND; i++) begin
            r = $urandom_range(0, 3);
            v[4*i +: 4] = (r == 0) ? 4'd0 : (r == 1) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        int k;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        // first frame, display all zeros
        wait_cyc(1);  chk("blank_c1", 32'(an), 'hF);
        wait_cyc(2);  chk("an_c2", 32'(an), 'hE);
        wait_cyc(5);  chk("an_c5", 32'(an), 'hE);
        wait_cyc(6);  chk("an_c6", 32'(an), 'hF);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        wait_cyc(8);  chk("an_c8", 32'(an), 'hF);
`else
        wait_cyc(8);  chk("an_c8", 32'(an), 'hD);
        wait_cyc(11); chk("an_c11", 32'(an), 'hD);
`endif
        wait_cyc(23); chk("fd_c23", 32'(frame_done), 0);
        wait_cyc(24); chk("fd_c24", 32'(frame_done), 1);
        wait_cyc(25); chk("fd_c25", 32'(frame_done), 0);
        wait_cyc(48); chk("fd_c48", 32'(frame_done), 1);
        // mid-frame load, commit at 72
        wait_cyc(50); do_load(16'h1234);
        chk("pend_after_load", 32'(pending), 1);
        chk("frame_unchanged", 32'(bcd_out), 0);
        wait_cyc(71); chk("pend_c71", 32'(pending), 1);
        wait_cyc(72); chk("fd_commit", 32'(frame_done), 1); chk("pend_commit", 32'(pending), 0);
        wait_cyc(74); chk("s0_bcd", 32'(bcd_out), 4); chk("s0_an", 32'(an), 'hE);
        wait_cyc(80); chk("s1_bcd", 32'(bcd_out), 3);
        wait_cyc(86); chk("s2_bcd", 32'(bcd_out), 2); chk("s2_an", 32'(an), 'hB);
        wait_cyc(92); chk("s3_bcd", 32'(bcd_out), 1); chk("s3_an", 32'(an), 'h7);
        // overwrite, then load coincident with boundary edge
        wait_cyc(100); do_load(16'h1111);
        wait_cyc(105); do_load(16'h2222);
        wait_cyc(119); do_load(16'h5555);
        chk("coinc_fd", 32'(frame_done), 1);
        chk("coinc_pend", 32'(pending), 1);
        chk("coinc_bcd", 32'(bcd_out), 2);
        wait_cyc(140); chk("ow_bcd", 32'(bcd_out), 2);
        wait_cyc(146); chk("next_bcd", 32'(bcd_out), 5); chk("next_pend", 32'(pending), 0);
        // invalid digit in slot 1
        wait_cyc(150); do_load(16'h12A4);
        wait_cyc(170); chk("inv_s0_an", 32'(an), 'hE); chk("inv_s0_bcd", 32'(bcd_out), 4);
        wait_cyc(176); chk("inv_s1_an", 32'(an), 'hF); chk("inv_s1_bcd", 32'(bcd_out), 'hA);
        wait_cyc(179); chk("inv_s1_an_end", 32'(an), 'hF);
        wait_cyc(182); chk("inv_s2_an", 32'(an), 'hB); chk("inv_s2_bcd", 32'(bcd_out), 2);
        wait_cyc(188); chk("inv_s3_an", 32'(an), 'h7); chk("inv_s3_bcd", 32'(bcd_out), 1);
        // leading zeros
        wait_cyc(195); do_load(16'h0042);
        wait_cyc(218); chk("lz_s0_an", 32'(an), 'hE); chk("lz_s0_bcd", 32'(bcd_out), 2);
        wait_cyc(224); chk("lz_s1_an", 32'(an), 'hD); chk("lz_s1_bcd", 32'(bcd_out), 4);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        wait_cyc(230); chk("lz_s2_an", 32'(an), 'hF);
        wait_cyc(236); chk("lz_s3_an", 32'(an), 'hF);
`else
        wait_cyc(230); chk("lz_s2_an", 32'(an), 'hB); chk("lz_s2_bcd", 32'(bcd_out), 0);
        wait_cyc(236); chk("lz_s3_an", 32'(an), 'h7);
`endif
        wait_cyc(245); do_load(16'h0000);
        wait_cyc(266); chk("z_s0_an", 32'(an), 'hE);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        wait_cyc(272); chk("z_s1_an", 32'(an), 'hF);
`else
        wait_cyc(272); chk("z_s1_an", 32'(an), 'hD);
`endif
        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 19) == 0);
            digits_in = rnd_digits();
        end
        @(negedge clk);
        do_load(16'h9876);
        // asynchronous reset while a digit is lit
        k = 0;
        while (an == 4'hF && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("lit_before_reset", (an != 4'hF) ? 1 : 0, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_an", 32'(an), 'hF);
        chk("rst_bcd", 32'(bcd_out), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_fd", 32'(frame_done), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_cyc(2); chk("rel_an_c2", 32'(an), 'hE); chk("rel_bcd", 32'(bcd_out), 0);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 15) == 0);
            digits_in = rnd_digits();
        end
        load = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller that shares one BCD-to-7-segment decoder among `NUM_DIGITS` common-anode digits. It holds a double-buffered digit register and presents one BCD code per slot on `bcd_out`, which feeds the shared decoder. It drives the active-low anode enables, inserts a ghost-suppression blanking gap between slots, and commits new display data only at frame boundaries so no frame is ever torn.

## Interface
- `NUM_DIGITS`, 4: digit slots scanned; ≥2.
- `REFRESH_DIV`, 1000: cycles each slot is lit; ≥1.
- `BLANK_CYCLES`, 16: all-off cycles before each slot; ≥1.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: reset is asynchronous and active-low.
- `load` input 1: one-cycle strobe; capture `digits_in` into the pending buffer.
- `digits_in` input 4*NUM_DIGITS: packed BCD; digit i at [4i+3:4i]; digit 0 is least significant.
- `bcd_out` output 4: BCD code of the current slot, to the shared decoder input.
- `an` output NUM_DIGITS: anode enables, active-low; at most one bit is 0.
- `pending` output 1: the pending buffer holds uncommitted data.
- `frame_done` output 1: one-cycle pulse at each frame boundary (commit point).

## Operation
- States: BLANK and SCAN. The cycle counter `cnt` and slot index `idx` are internal.
- BLANK:
  - `an` is all 1s.
  - `bcd_out` = active[idx].
  - `cnt` runs 0..BLANK_CYCLES-1, then the block goes to SCAN with `cnt` = 0.
- SCAN:
  - `an[idx]` = 0 unless the slot is suppressed; all other bits are 1.
  - `cnt` runs 0..REFRESH_DIV-1, then the block goes to BLANK with `idx` = idx+1.
  - `idx` wraps from NUM_DIGITS-1 to 0.
- Suppressed slot: the active digit is >9 (invalid BCD), or it is a leading zero (see Configuration). In a suppressed slot, `an` stays all 1s for the whole SCAN period, and timing is unchanged.
- Frame boundary: the SCAN→BLANK edge where `idx` wraps to 0. On that edge:
  - If `pending` = 1, active is loaded from pending and `pending` clears.
  - `frame_done` = 1 for one cycle, whether or not a commit occurred.
- `load`:
  - Pending is loaded with `digits_in` and `pending` is set.
  - A second `load` before commit overwrites pending; the last value wins.
- `load` on the frame-boundary edge:
  - The commit uses the old pending value.
  - Pending is then loaded with the new `digits_in`.
  - `pending` stays 1.
- Frame length is NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- All outputs are registered.

## Timing
- Reset values, applied asynchronously while `reset_n` = 0:
  - State = BLANK, `cnt` = 0, `idx` = 0.
  - Active and pending buffers = 0.
  - `pending` = 0, `frame_done` = 0.
  - `an` = all 1s, `bcd_out` = 0.
- After reset release:
  - The first BLANK spans cycles 0..BLANK_CYCLES-1.
  - Slot 0 is lit for cycles BLANK_CYCLES..BLANK_CYCLES+REFRESH_DIV-1.
- `pending` rises the cycle after `load` is sampled.
- Display latency from `load` to the first lit new digit: from one BLANK period up to one frame plus one BLANK period.
- `bcd_out` changes only on entry to BLANK, never while any anode is low.
- Reset mid-scan: all outputs return to reset values immediately. Pending data is discarded.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN` defined:
  - Scanning from digit NUM_DIGITS-1 downward, every zero digit before the first nonzero digit is suppressed.
  - Digit 0 is never suppressed as a leading zero.
  - A leading-zero run ends at an invalid digit.
- Not defined: zero digits are lit normally. Only invalid digits are suppressed.

## Test plan
- Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2.
- Reset and first frame:
  - Assert `reset_n` low mid-run: `an`=4'b1111, `bcd_out`=0, `pending`=0, `frame_done`=0 immediately.
  - After release: `an`=4'b1110 on cycles 2–5, 4'b1101 on cycles 8–11, and `frame_done` pulses once per 24 cycles.
- Commit at boundary:
  - `load` 16'h1234 mid-frame: `pending`=1, and the current frame is unchanged.
  - At the boundary, `frame_done`=1 and `pending`=0 on the same cycle.
  - Next frame: `bcd_out`=4,3,2,1 for slots 0–3.
- Overwrite and coincident load:
  - `load` 16'h1111 then 16'h2222 before the boundary: 2222 is committed.
  - `load` 16'h5555 exactly on the boundary edge: 2222 is committed, `pending` stays 1, and 5555 shows in the following frame.
- Invalid digit: committed 16'h12A4 → slot 1 keeps `an`=4'b1111 during its SCAN; slots 0, 2 and 3 light with 4, 2, 1.
- Leading-zero option, committed 16'h0042:
  - With the macro: slots 3 and 2 stay dark; slots 1 and 0 show 4 and 2.
  - Without the macro: all four slots light, showing 2, 4, 0, 0.
  - Committed 16'h0000 with the macro: only slot 0 lights.
- Invariant (checked every cycle): at most one `an` bit is 0, and `bcd_out` never changes while any `an` bit is 0.
